// File: rtl/addsub_pkg.sv
// Shared types for the pipelined add/subtract unit: opcode enum, flag bundle
// and the signed saturation constant.
package addsub_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        ADC = 2'd1,
        SUB = 2'd2,
        SBB = 2'd3
    } op_e;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } flags_t;

    localparam int MAX_W = 64;

    // Largest positive value for sign=0, most negative value for sign=1, n bits wide.
    function automatic logic [MAX_W-1:0] sat_value(input logic sign, input int n);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == n - 1) begin
                r[i] = sign;
            end else if (i < n - 1) begin
                r[i] = ~sign;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_if.sv
// Operand/result handshake bundle for addsub_pipe; master issues operands,
// slave (the unit) returns results.
interface addsub_if #(
    parameter int N = 32
);
    import addsub_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    op_e          in_op;
    logic         in_cin;
    logic         in_sat;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_s;
    logic         out_c;
    logic         out_v;
    logic         out_z;
    logic         out_n;

    modport master (
        output in_valid, in_a, in_b, in_op, in_cin, in_sat, out_ready,
        input  in_ready, out_valid, out_s, out_c, out_v, out_z, out_n
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_cin, in_sat, out_ready,
        output in_ready, out_valid, out_s, out_c, out_v, out_z, out_n
    );

endinterface

// File: rtl/addsub_slice.sv
// Combinational W-bit Kogge-Stone adder slice with carry-in; also exposes the
// carry into the slice MSB so the top slice can form signed overflow.
module addsub_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_into_msb
);
    logic [W-1:0] g, p, gg, pp, ng, np;
    logic [W:0]   carry;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = g;
        pp = p;
        ng = g;
        np = p;
        // After the prefix levels gg/pp hold group generate/propagate over [i:0].
        for (int d = 1; d < W; d = d * 2) begin
            ng = gg;
            np = pp;
            for (int i = d; i < W; i++) begin
                ng[i] = gg[i] | (pp[i] & gg[i-d]);
                np[i] = pp[i] & pp[i-d];
            end
            gg = ng;
            pp = np;
        end
        carry[0] = cin;
        for (int i = 0; i < W; i++) begin
            carry[i+1] = gg[i] | (pp[i] & cin);
        end
        sum = p ^ carry[W-1:0];
    end

    assign cout       = carry[W];
    assign c_into_msb = carry[W-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined N-bit add/subtract unit: the carry chain is cut into STAGES
// registered slices, flags and saturation are formed in the last stage.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    addsub_if.slave  bus
);
    localparam int W    = N / STAGES;
    localparam int L    = STAGES - 1;
    localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

    if ((N % STAGES) != 0 || STAGES < 1 || STAGES > 8 || N > MAX_W) begin : g_bad_param
        $error("addsub_pipe: illegal N/STAGES combination");
    end

    // a/b carry the not-yet-added slices, s the finished ones, cm the carry into the latest slice MSB.
    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] s;
        logic         c;
        logic         cm;
        logic         z;
        logic         sat;
    } beat_t;

    beat_t               pin    [STAGES];
    beat_t               nxt    [STAGES];
    beat_t               pipe_p [NREG];
    logic [NREG-1:0]     vld_p;
    logic [NREG:0]       vchain;
    logic [W-1:0]        sl_sum [STAGES];
    logic [STAGES-1:0]   sl_cout;
    logic [STAGES-1:0]   sl_cmsb;

    logic                stall;
    logic                fin_vld;
    logic                sub;
    logic                cin_eff;
    logic                out_vld_q;
    logic [N-1:0]        out_s_q;
    flags_t              flags_q;

    assign stall        = out_vld_q & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    assign sub = (bus.in_op == SUB) || (bus.in_op == SBB);

    always_comb begin
        cin_eff = 1'b0;
        case (bus.in_op)
            ADD:     cin_eff = 1'b0;
            ADC:     cin_eff = bus.in_cin;
            SUB:     cin_eff = 1'b1;
            SBB:     cin_eff = bus.in_cin;
            default: cin_eff = 1'b0;
        endcase
    end

    assign pin[0] = '{a: bus.in_a, b: (sub ? ~bus.in_b : bus.in_b), s: '0,
                      c: cin_eff, cm: 1'b0, z: 1'b1, sat: bus.in_sat};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_slice #(.W(W)) u_slice (
            .a          (pin[k].a[k*W +: W]),
            .b          (pin[k].b[k*W +: W]),
            .cin        (pin[k].c),
            .sum        (sl_sum[k]),
            .cout       (sl_cout[k]),
            .c_into_msb (sl_cmsb[k])
        );

        always_comb begin
            nxt[k]              = pin[k];
            nxt[k].s[k*W +: W]  = sl_sum[k];
            nxt[k].c            = sl_cout[k];
            nxt[k].cm           = sl_cmsb[k];
            nxt[k].z            = pin[k].z & ~(|sl_sum[k]);
        end

        // ---- stage k / stage k+1 boundary ----
        if (k < L) begin : g_reg
            always_ff @(posedge clk) begin
                if (!stall && !flush) begin
                    pipe_p[k] <= nxt[k];
                end
            end
            assign pin[k+1] = pipe_p[k];
        end
    end

    assign vchain  = {vld_p, bus.in_valid};
    assign fin_vld = (STAGES == 1) ? bus.in_valid : vchain[NREG];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            vld_p <= '0;
        end else if (!stall) begin
            vld_p <= vchain[NREG-1:0];
        end
    end

    logic         v_fin;
    logic         satv;
    logic [N-1:0] sat_s;
    logic [N-1:0] s_fin;
    flags_t       f_fin;

    assign sat_s = N'(sat_value(nxt[L].a[N-1], N));

    always_comb begin
        v_fin   = nxt[L].c ^ nxt[L].cm;
        satv    = nxt[L].sat & v_fin;
        s_fin   = satv ? sat_s : nxt[L].s;
        f_fin.c = nxt[L].c;
        f_fin.v = v_fin;
        f_fin.z = nxt[L].z & ~satv;
        f_fin.n = s_fin[N-1];
    end

    // ---- final stage / output register boundary ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_s_q   <= '0;
            flags_q   <= '0;
        end else if (flush) begin
            out_vld_q <= 1'b0;
        end else if (!stall) begin
            out_vld_q <= fin_vld;
            if (fin_vld) begin
                out_s_q <= s_fin;
                flags_q <= f_fin;
            end
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_s     = out_s_q;
    assign bus.out_c     = flags_q.c;
    assign bus.out_v     = flags_q.v;
    assign bus.out_z     = flags_q.z;
    assign bus.out_n     = flags_q.n;

endmodule
